// File: rtl/pov_pkg.sv
// pov_pkg: default geometry and state type shared by the POV column engine.
package pov_pkg;
  localparam int POV_NUM_LEDS = 16;
  localparam int POV_COLS = 72;
  localparam int POV_STEPS_PER_COL = 5;
  typedef enum logic {POV_UNSYNC, POV_RUN} pov_state_t;
endpackage

// File: rtl/pov_column_engine_sync_edge.sv
// pov_sync_edge: two-flop synchroniser plus rising-edge detect for an asynchronous sensor input.
module pov_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic rise
);
  logic [2:0] sr;
  always_ff @(posedge clk)
    if (rst) sr <= '0;
    else sr <= {sr[1:0], raw};
  assign rise = sr[1] & ~sr[2];
endmodule

// File: rtl/pov_column_engine.sv
// pov_column_engine: counts fan steps into a column position and drives the LED bar from a writable pattern memory.
// Define POV_INDEX_SYNC_EN to enable index synchronisation (UNSYNC state, sync_err); otherwise the block free-runs.
module pov_column_engine
  import pov_pkg::*;
#(
  parameter int NUM_LEDS = POV_NUM_LEDS,
  parameter int COLS = POV_COLS,
  parameter int STEPS_PER_COL = POV_STEPS_PER_COL,
  localparam int CW = $clog2(COLS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fanclk,
  input  logic                index,
  input  logic [CW-1:0]       offset,
  input  logic                wr_en,
  input  logic [CW-1:0]       wr_addr,
  input  logic [NUM_LEDS-1:0] wr_data,
  output logic [NUM_LEDS-1:0] led,
  output logic                rev_done,
  output logic                sync_err
);
  localparam int SW = STEPS_PER_COL > 1 ? $clog2(STEPS_PER_COL) : 1;
  logic [NUM_LEDS-1:0] mem [COLS];
  pov_state_t state, state_n;
  logic [SW-1:0] sub, sub_n;
  logic [CW-1:0] col, col_n, offs, col_eff;
  logic [CW:0] sum;
  logic fan_rise, idx_rise, last_sub, last_col, wrap, rev_n, err_n;
  pov_sync_edge fan_sync (.clk(clk), .rst(rst), .raw(fanclk), .rise(fan_rise));
`ifdef POV_INDEX_SYNC_EN
  localparam pov_state_t RST_STATE = POV_UNSYNC;
  pov_sync_edge idx_sync (.clk(clk), .rst(rst), .raw(index), .rise(idx_rise));
`else
  localparam pov_state_t RST_STATE = POV_RUN;
  logic unused_index;
  assign unused_index = index;
  assign idx_rise = 1'b0;
`endif
  assign last_sub = sub == SW'(STEPS_PER_COL - 1);
  assign last_col = col == CW'(COLS - 1);
  assign wrap = fan_rise && last_sub && last_col;
  assign offs = int'(offset) >= COLS ? '0 : offset;
  assign sum = {1'b0, col} + {1'b0, offs};
  assign col_eff = int'(sum) >= COLS ? CW'(int'(sum) - COLS) : sum[CW-1:0];
  // An index edge swallows a coincident fan edge; landing exactly on the wrap is still a clean revolution.
  always_comb begin
    state_n = state;
    sub_n = sub;
    col_n = col;
    rev_n = 1'b0;
    err_n = 1'b0;
    if (idx_rise) begin
      state_n = POV_RUN;
      sub_n = '0;
      col_n = '0;
      rev_n = state == POV_RUN && wrap;
      err_n = state == POV_RUN && !wrap && (sub != '0 || col != '0);
    end else if (state == POV_RUN && fan_rise) begin
      sub_n = last_sub ? '0 : sub + 1'b1;
      col_n = !last_sub ? col : last_col ? '0 : col + 1'b1;
      rev_n = wrap;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= RST_STATE;
      sub <= '0;
      col <= '0;
      led <= '0;
      rev_done <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      state <= state_n;
      sub <= sub_n;
      col <= col_n;
      led <= state == POV_RUN ? mem[col_eff] : '0;
      rev_done <= rev_n;
      sync_err <= err_n;
    end
  // Pattern memory is host-owned: no reset, writes accepted at all times.
  always_ff @(posedge clk)
    if (wr_en && int'(wr_addr) < COLS) mem[wr_addr] <= wr_data;
endmodule

// File: tb/tb_pov_column_engine.sv
// tb_pov_column_engine: directed scoreboard bench; expected outputs are queued per clock cycle and checked by a monitor.
module tb_pov_column_engine;
  logic clk = 0, rst, fanclk, index, wr_en;
  logic [6:0] offset, wr_addr;
  logic [15:0] wr_data, led;
  logic rev_done, sync_err;
  int cyc = 0, passed = 0, total = 0, nrev = 0, nerr = 0, rev_seen = 0, err_seen = 0;
  typedef struct {
    int cyc;
    logic [15:0] led;
    bit cl;
    logic rev;
    logic err;
    int rc;
    int ec;
    string nm;
  } ent_t;
  ent_t sb[$];

  pov_column_engine dut (
    .clk(clk), .rst(rst), .fanclk(fanclk), .index(index), .offset(offset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .led(led), .rev_done(rev_done), .sync_err(sync_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    wr_en = 1;
    wr_addr = 7'(a);
    wr_data = d;
    tick(1);
    wr_en = 0;
  endtask

  task automatic pulse();
    fanclk = 1;
    tick(1);
    fanclk = 0;
    tick(1);
  endtask

  task automatic idx_pulse(input bit with_fan);
    index = 1;
    fanclk = with_fan;
    tick(1);
    index = 0;
    fanclk = 0;
    tick(1);
  endtask

  function automatic void ex(input int dt, input logic [15:0] l, input bit cl, input logic r, input logic e, input string nm);
    ent_t x;
    x.cyc = cyc + dt;
    x.led = l;
    x.cl = cl;
    x.rev = r;
    x.err = e;
    x.rc = nrev;
    x.ec = nerr;
    x.nm = nm;
    sb.push_back(x);
  endfunction

  initial forever begin
    ent_t e;
    @(negedge clk);
    if (rev_done === 1'b1) rev_seen++;
    if (sync_err === 1'b1) err_seen++;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      total++;
      if (e.cyc == cyc && (!e.cl || led === e.led) && rev_done === e.rev && sync_err === e.err && rev_seen == e.rc && err_seen == e.ec)
        passed++;
      else
        $display("FAIL %s: got cyc=%0d led=%h rev_done=%b sync_err=%b revs=%0d errs=%0d, want cyc=%0d led=%h(chk=%0b) rev_done=%b sync_err=%b revs=%0d errs=%0d",
                 e.nm, cyc, led, rev_done, sync_err, rev_seen, err_seen, e.cyc, e.led, e.cl, e.rev, e.err, e.rc, e.ec);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d done", passed, total);
    $fatal(1);
  end

  initial begin
    rst = 1; fanclk = 0; index = 0; offset = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    tick(1);
    ex(0, 16'h0000, 1, 0, 0, "reset_led");
    fanclk = 1; wr(0, 16'h0004);
    fanclk = 0; wr(1, 16'h0008);
    fanclk = 1; wr(2, 16'h0010);
    fanclk = 0; wr(71, 16'h8001);
    fanclk = 1; wr(5, 16'h00a5);
    ex(0, 16'h0000, 1, 0, 0, "reset_fan_toggle");
    rst = 0;
    tick(1);
`ifdef POV_INDEX_SYNC_EN
    ex(0, 16'h0000, 1, 0, 0, "release_unsync");
    fanclk = 0;
    tick(1);
    pulse();
    pulse();
    ex(2, 16'h0000, 1, 0, 0, "unsync_fan_ignored");
    idx_pulse(0);
    ex(1, 16'h0000, 1, 0, 0, "first_index_no_err");
    ex(2, 16'h0004, 1, 0, 0, "first_index_run");
    repeat (5) pulse();
    ex(1, 16'h0004, 1, 0, 0, "run_col0");
    ex(2, 16'h0008, 1, 0, 0, "run_col1");
    repeat (95) pulse();
    tick(3);
    offset = 5;
    tick(2);
    idx_pulse(0);
    nerr++;
    ex(1, 16'h0000, 0, 0, 1, "index_misaligned_err");
    ex(2, 16'h00a5, 1, 0, 0, "index_realign_led");
    idx_pulse(0);
    ex(1, 16'h00a5, 1, 0, 0, "index_at_origin");
    repeat (359) pulse();
    pulse();
    nrev++;
    ex(1, 16'h0000, 0, 1, 0, "rev_plain");
    ex(2, 16'h00a5, 1, 0, 0, "rev_plain_col0");
    repeat (359) pulse();
    idx_pulse(1);
    nrev++;
    ex(1, 16'h0000, 0, 1, 0, "index_coincident_wrap");
    ex(2, 16'h00a5, 1, 0, 0, "index_coincident_led");
    offset = 0;
    tick(3);
    idx_pulse(1);
    ex(1, 16'h0004, 1, 0, 0, "index_fan_priority");
    repeat (4) pulse();
    ex(2, 16'h0004, 1, 0, 0, "fan_edge_consumed");
    pulse();
    ex(2, 16'h0008, 1, 0, 0, "after_priority_col1");
    rst = 1;
    ex(1, 16'h0000, 1, 0, 0, "midrst_led");
    tick(2);
    rst = 0;
    tick(1);
    pulse();
    ex(2, 16'h0000, 1, 0, 0, "midrst_unsync");
`else
    ex(0, 16'h0004, 1, 0, 0, "release_run_mem0");
    fanclk = 0;
    tick(1);
    repeat (4) pulse();
    ex(1, 16'h0004, 1, 0, 0, "held_reset_step_col0");
    ex(2, 16'h0008, 1, 0, 0, "held_reset_step_col1");
    tick(4);
    offset = 71;  ex(1, 16'h0004, 1, 0, 0, "offset71_wrap"); tick(1);
    offset = 70;  ex(1, 16'h8001, 1, 0, 0, "offset70");      tick(1);
    offset = 4;   ex(1, 16'h00a5, 1, 0, 0, "offset4");       tick(1);
    offset = 100; ex(1, 16'h0008, 1, 0, 0, "offset100_zero"); tick(1);
    offset = 4;   ex(1, 16'h00a5, 1, 0, 0, "offset4_again"); tick(1);
    offset = 127; ex(1, 16'h0008, 1, 0, 0, "offset127_zero"); tick(1);
    offset = 0;
    tick(2);
    ex(1, 16'h0008, 1, 0, 0, "write_read_before");
    ex(2, 16'h1234, 1, 0, 0, "write_displayed");
    wr(1, 16'h1234);
    tick(2);
    fanclk = 1;
    tick(50);
    fanclk = 0;
    tick(4);
    repeat (3) pulse();
    ex(2, 16'h1234, 1, 0, 0, "hold50_sub4");
    pulse();
    ex(2, 16'h0010, 1, 0, 0, "hold50_col2");
    repeat (345) pulse();
    tick(3);
    ex(0, 16'h8001, 1, 0, 0, "col71_no_rev");
    offset = 1;
    ex(1, 16'h0004, 1, 0, 0, "col71_offset1");
    tick(1);
    offset = 0;
    tick(1);
    repeat (4) pulse();
    pulse();
    nrev++;
    ex(1, 16'h8001, 1, 1, 0, "rev_wrap_pulse");
    ex(2, 16'h0004, 1, 0, 0, "rev_col0");
    repeat (7) pulse();
    tick(2);
    rst = 1;
    ex(1, 16'h0000, 1, 0, 0, "midrst_led");
    tick(2);
    rst = 0;
    ex(1, 16'h0004, 1, 0, 0, "midrst_col0");
    tick(1);
    repeat (4) pulse();
    ex(2, 16'h0004, 1, 0, 0, "midrst_sub0");
    pulse();
    ex(2, 16'h1234, 1, 0, 0, "midrst_pattern_kept");
`endif
    tick(6);
    if (sb.size() != 0) begin
      total++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
